// File: rtl/game_io_pkg.sv
// Shared types for the game I/O write path: regfile geometry, write record and
// write-port arbiter state encoding.
package game_io_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] SCORE_REG = 5'd30;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } wport_state_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of CPU write-port inputs, requester handshakes and regfile write outputs
// seen by regfile_wport_arbiter (slave) and whoever drives it (master).
interface regfile_wport_arbiter_if
    import game_io_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic                           cpu_we;
    logic [RF_ADDR_W-1:0]           cpu_rd;
    logic [RF_DATA_W-1:0]           cpu_data;
    logic [NUM_REQ-1:0]             req_valid;
    logic [RF_ADDR_W*NUM_REQ-1:0]   req_rd;
    logic [RF_DATA_W*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rf_we;
    logic [RF_ADDR_W-1:0]           rf_rd;
    logic [RF_DATA_W-1:0]           rf_data;
    logic                           ext_write;
    logic [3:0]                     fifo_count;
    logic                           cpu_stall;

    modport master (
        output cpu_we, cpu_rd, cpu_data, req_valid, req_rd, req_data,
        input  req_ready, rf_we, rf_rd, rf_data, ext_write, fifo_count, cpu_stall
    );

    modport slave (
        input  cpu_we, cpu_rd, cpu_data, req_valid, req_rd, req_data,
        output req_ready, rf_we, rf_rd, rf_data, ext_write, fifo_count, cpu_stall
    );

endinterface

// File: rtl/wport_fifo.sv
// Synchronous FIFO of regfile write records; occupancy held in its own counter so
// full and empty stay distinct when the power-of-two pointers wrap.
module wport_fifo
    import game_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  rf_wr_t     din_i,
    input  logic       pop_i,
    output rf_wr_t     dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_wr_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == 4'(DEPTH));
    assign empty_o = (count_q == 4'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + 4'(push_ok) - 4'(pop_ok);
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between the CPU and buffered game-logic requesters.
// Define WR_STARVE_STALL_EN to stall the CPU when a queued write waits too long.
module regfile_wport_arbiter
    import game_io_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_wport_arbiter_if.slave bus
);
    wport_state_t state_q, settle_state;
    logic [1:0]   rr_ptr_q, rr_d, win;
    logic         found, xfer, push, pop, force_drain, fifo_full, fifo_empty;
    logic [3:0]   count, count_d;
    rf_wr_t       win_wr, head;

    // Round-robin: first valid at or above rr_ptr, otherwise first valid below it.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        win_wr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (i >= int'(rr_ptr_q))) begin
                found       = 1'b1;
                win         = 2'(i);
                win_wr.rd   = bus.req_rd[RF_ADDR_W*i +: RF_ADDR_W];
                win_wr.data = bus.req_data[RF_DATA_W*i +: RF_DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (i < int'(rr_ptr_q))) begin
                found       = 1'b1;
                win         = 2'(i);
                win_wr.rd   = bus.req_rd[RF_ADDR_W*i +: RF_ADDR_W];
                win_wr.data = bus.req_data[RF_DATA_W*i +: RF_DATA_W];
            end
        end
    end

    assign rr_d = (int'(win) == NUM_REQ - 1) ? 2'd0 : win + 2'd1;
    assign xfer = reset_n && !fifo_full && found;
    assign push = xfer && (win_wr.rd != '0);

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = xfer && (win == 2'(i));
        end
    end

`ifdef WR_STARVE_STALL_EN
    assign force_drain = (state_q == FORCE);
`else
    assign force_drain = 1'b0;
`endif

    assign pop = reset_n && !fifo_empty && (force_drain || (state_q == PEND && !bus.cpu_we));

    // A drain always owns the port; in FORCE that also swallows the frozen CPU write.
    always_comb begin
        if (pop) begin
            bus.rf_we   = 1'b1;
            bus.rf_rd   = head.rd;
            bus.rf_data = head.data;
        end else begin
            bus.rf_we   = bus.cpu_we;
            bus.rf_rd   = bus.cpu_rd;
            bus.rf_data = bus.cpu_data;
        end
    end

    assign bus.ext_write  = pop;
    assign bus.fifo_count = count;
    assign count_d        = count + 4'(push) - 4'(pop);
    assign settle_state   = (count_d == 4'd0) ? EMPTY : PEND;

    wport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .din_i   (win_wr),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

`ifdef WR_STARVE_STALL_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q;
    logic          stall_q;

    assign bus.cpu_stall = stall_q;
`else
    localparam int starve_limit_unused = STARVE_LIMIT;

    assign bus.cpu_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            state_q  <= EMPTY;
`ifdef WR_STARVE_STALL_EN
            starve_q <= '0;
            stall_q  <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                rr_ptr_q <= rr_d;
            end
`ifdef WR_STARVE_STALL_EN
            starve_q <= (state_q == PEND && !pop) ? starve_q + 1'b1 : '0;
            if (state_q == FORCE) begin
                if (pop) begin
                    stall_q <= 1'b0;
                    state_q <= settle_state;
                end
            end else if (state_q == PEND && !pop && starve_q == SW'(STARVE_LIMIT - 1)) begin
                stall_q <= 1'b1;
                state_q <= FORCE;
            end else begin
                state_q <= settle_state;
            end
`else
            state_q <= settle_state;
`endif
        end
    end

endmodule
